// File: rtl/adc_test_source.sv
// adc_test_source: synthetic ADC data source for the 4-channel capture path.
//
// Produces 10-bit offset-binary samples in the same format as the ADC deserialiser.
// Each burst is a sync preamble (alternating all-ones/all-zeros words) followed by a
// payload (midscale, ramp, fixed value or PRBS). Start/stop/done handshakes frame the burst.
//
// Optional feature: define ADC_TEST_SRC_PRBS_EN to enable the mode-3 PRBS generator
// (15-bit LFSR, x^15+x^14+1). Without it, mode 3 emits midscale.
//
// Ports:
//   clk_div_a        sample-word clock
//   rst_n            synchronous active-low reset
//   start            one-cycle pulse, starts a burst when idle
//   stop             one-cycle pulse, aborts a burst in SYNC or RUN
//   mode             pattern select (0 midscale, 1 ramp, 2 fixed, 3 PRBS), captured at start
//   fixed_val        signed value for mode 2, captured at start
//   sync_len         preamble length in cycles, captured at start
//   burst_len        payload length in cycles (0 = continuous), captured at start
//   dataA..D_out     SERDES_RATIO lanes of 10 bits each; lane 0 is the oldest sample
//   data_valid       high on payload cycles
//   sync_active      high on preamble cycles
//   busy             high in SYNC and RUN
//   done             one-cycle pulse when a burst ends
module adc_test_source #(
    parameter int unsigned SERDES_RATIO = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                         clk_div_a,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [1:0]                   mode,
    input  logic [9:0]                   fixed_val,
    input  logic [3:0]                   sync_len,
    input  logic [CNT_W-1:0]             burst_len,
    output logic [SERDES_RATIO*10-1:0]   dataA_out,
    output logic [SERDES_RATIO*10-1:0]   dataB_out,
    output logic [SERDES_RATIO*10-1:0]   dataC_out,
    output logic [SERDES_RATIO*10-1:0]   dataD_out,
    output logic                         data_valid,
    output logic                         sync_active,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned DW  = SERDES_RATIO * 10;
    localparam logic [9:0]  MID = 10'h200;

    typedef enum logic [1:0] {StIdle, StSync, StRun, StDone} state_e;

    state_e           state_q;
    logic [1:0]       mode_q;
    logic [9:0]       fixed_q;
    logic [3:0]       sync_len_q;
    logic [CNT_W-1:0] burst_len_q;
    // Counts emitted preamble words in SYNC, emitted payload words in RUN.
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    data_q [4];

`ifdef ADC_TEST_SRC_PRBS_EN
    localparam logic [14:0] SEED = 15'h7FFF;

    logic [14:0] lfsr_q;
    logic [14:0] pay_lfsr;

    function automatic logic [14:0] lfsr_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    // Bits [9:0] of s rotated left (within 15 bits) by n.
    function automatic logic [9:0] rot_lane(input logic [14:0] s, input int n);
        logic [9:0] r;
        int m;
        m = n % 15;
        for (int b = 0; b < 10; b++) begin
            r[b] = s[(b + 15 - m) % 15];
        end
        return r;
    endfunction
`endif

    // Pattern inputs for the payload word about to be registered. Leaving IDLE uses the
    // live inputs (they are being captured on the same edge); later cycles use captures.
    logic          in_idle;
    logic [1:0]    pay_mode;
    logic [9:0]    pay_fixed;
    logic [9:0]    pay_k;
    logic [9:0]    lane;
    logic [DW-1:0] pre_word;
    logic [DW-1:0] pay  [4];
    logic [DW-1:0] pre  [4];
    logic [DW-1:0] mid  [4];

    assign in_idle   = (state_q == StIdle);
    assign pay_mode  = in_idle ? mode : mode_q;
    assign pay_fixed = in_idle ? fixed_val : fixed_q;
    // Payload k=0 is emitted when leaving IDLE or SYNC; inside RUN k equals the count.
    assign pay_k     = (state_q == StRun) ? cnt_q[9:0] : 10'd0;
    // Preamble j=0 is emitted when leaving IDLE; inside SYNC j equals the count.
    assign pre_word  = (in_idle || !cnt_q[0]) ? {DW{1'b1}} : {DW{1'b0}};
`ifdef ADC_TEST_SRC_PRBS_EN
    assign pay_lfsr  = in_idle ? SEED : lfsr_q;
`endif

    always_comb begin
        lane = MID;
        for (int c = 0; c < 4; c++) begin
            pre[c] = pre_word;
            mid[c] = {SERDES_RATIO{MID}};
            pay[c] = '0;
            for (int i = 0; i < int'(SERDES_RATIO); i++) begin
                unique case (pay_mode)
                    2'd1:    lane = (pay_k * 10'(SERDES_RATIO) + 10'(i) + 10'(c * 256)) ^ MID;
                    2'd2:    lane = pay_fixed ^ MID;
`ifdef ADC_TEST_SRC_PRBS_EN
                    2'd3:    lane = rot_lane(pay_lfsr, c * int'(SERDES_RATIO) + i);
`endif
                    default: lane = MID;
                endcase
                pay[c][i*10 +: 10] = lane;
            end
        end
    end

    always_ff @(posedge clk_div_a) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            fixed_q     <= '0;
            sync_len_q  <= '0;
            burst_len_q <= '0;
            cnt_q       <= '0;
            data_q      <= mid;
            data_valid  <= 1'b0;
            sync_active <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef ADC_TEST_SRC_PRBS_EN
            lfsr_q      <= '0;
`endif
        end else begin
            // Idle-looking defaults; the branches below override for active cycles.
            data_q      <= mid;
            data_valid  <= 1'b0;
            sync_active <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q      <= mode;
                        fixed_q     <= fixed_val;
                        sync_len_q  <= sync_len;
                        burst_len_q <= burst_len;
                        cnt_q       <= CNT_W'(1);
                        busy        <= 1'b1;
                        if (sync_len != 4'd0) begin
                            state_q     <= StSync;
                            sync_active <= 1'b1;
                            data_q      <= pre;
`ifdef ADC_TEST_SRC_PRBS_EN
                            lfsr_q      <= SEED;
`endif
                        end else begin
                            state_q    <= StRun;
                            data_valid <= 1'b1;
                            data_q     <= pay;
`ifdef ADC_TEST_SRC_PRBS_EN
                            lfsr_q     <= lfsr_step(pay_lfsr);
`endif
                        end
                    end
                end
                StSync: begin
                    if (stop) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else if (cnt_q == CNT_W'(sync_len_q)) begin
                        state_q    <= StRun;
                        cnt_q      <= CNT_W'(1);
                        busy       <= 1'b1;
                        data_valid <= 1'b1;
                        data_q     <= pay;
`ifdef ADC_TEST_SRC_PRBS_EN
                        lfsr_q     <= lfsr_step(pay_lfsr);
`endif
                    end else begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        busy        <= 1'b1;
                        sync_active <= 1'b1;
                        data_q      <= pre;
                    end
                end
                StRun: begin
                    // stop wins over normal completion on the same edge.
                    if (stop || (burst_len_q != '0 && cnt_q == burst_len_q)) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        busy       <= 1'b1;
                        data_valid <= 1'b1;
                        data_q     <= pay;
`ifdef ADC_TEST_SRC_PRBS_EN
                        lfsr_q     <= lfsr_step(pay_lfsr);
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign dataA_out = data_q[0];
    assign dataB_out = data_q[1];
    assign dataC_out = data_q[2];
    assign dataD_out = data_q[3];

endmodule

// File: tb/tb_adc_test_source.sv
// Testbench for adc_test_source: table of bursts plus hand-written corner sequences.
// Expected words come from a scoreboard queue filled by an independent pattern model.
module tb_adc_test_source;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [9:0]  fixed_val = 10'd0;
    logic [3:0]  sync_len = 4'd0;
    logic [15:0] burst_len = 16'd0;
    logic [39:0] dataA_out, dataB_out, dataC_out, dataD_out;
    logic        data_valid, sync_active, busy, done;

    always #5 clk = ~clk;

    adc_test_source #(.SERDES_RATIO(4), .CNT_W(16)) dut (
        .clk_div_a   (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .fixed_val   (fixed_val),
        .sync_len    (sync_len),
        .burst_len   (burst_len),
        .dataA_out   (dataA_out),
        .dataB_out   (dataB_out),
        .dataC_out   (dataC_out),
        .dataD_out   (dataD_out),
        .data_valid  (data_valid),
        .sync_active (sync_active),
        .busy        (busy),
        .done        (done)
    );

    // flags = {data_valid, sync_active, busy, done}
    typedef struct {
        logic [39:0] a, b, c, d;
        logic [3:0]  flags;
        bit          fp;
    } exp_t;

    typedef struct {
        int          md;
        logic [9:0]  fv;
        logic [3:0]  sl;
        logic [15:0] bl;
        logic [39:0] first_a;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[6];
    int          total = 0;
    int          bad = 0;
    int          done_seen = 0;
    int          d0;
    logic [39:0] cur_first;

    task automatic check40(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] exp_word(input int md, input logic [9:0] fv, input int k,
                                             input logic [14:0] s, input int c);
        logic [39:0] w;
        logic [9:0]  ln;
        logic [29:0] sh;
        for (int i = 0; i < 4; i++) begin
            case (md)
                1: ln = 10'((4 * k + i + 256 * c) % 1024) ^ 10'h200;
                2: ln = fv ^ 10'h200;
`ifdef ADC_TEST_SRC_PRBS_EN
                3: begin
                    sh = {s, s} >> (15 - (4 * c + i));
                    ln = sh[9:0];
                end
`endif
                default: ln = 10'h200;
            endcase
            w[i*10 +: 10] = ln;
        end
        sh = {s, s};
        return w;
    endfunction

    task automatic push_idle(input int n);
        exp_t e;
        e.a = {4{10'h200}}; e.b = e.a; e.c = e.a; e.d = e.a;
        e.flags = 4'b0000; e.fp = 1'b0;
        repeat (n) sb.push_back(e);
    endtask

    task automatic push_burst(input int md, input logic [9:0] fv, input int npre,
                              input int npay, input bit dn);
        exp_t        e;
        logic [14:0] s;
        logic [9:0]  pl;
        s = 15'h7FFF;
        for (int j = 0; j < npre; j++) begin
            pl = (j % 2 == 0) ? 10'h3FF : 10'h000;
            e.a = {4{pl}}; e.b = e.a; e.c = e.a; e.d = e.a;
            e.flags = 4'b0110; e.fp = 1'b0;
            sb.push_back(e);
        end
        for (int k = 0; k < npay; k++) begin
            e.a = exp_word(md, fv, k, s, 0);
            e.b = exp_word(md, fv, k, s, 1);
            e.c = exp_word(md, fv, k, s, 2);
            e.d = exp_word(md, fv, k, s, 3);
            e.flags = 4'b1010; e.fp = (k == 0);
            sb.push_back(e);
            s = {s[13:0], s[14] ^ s[13]};
        end
        if (dn) begin
            e.a = {4{10'h200}}; e.b = e.a; e.c = e.a; e.d = e.a;
            e.flags = 4'b0001; e.fp = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check40("dataA", dataA_out, e.a);
            check40("dataB", dataB_out, e.b);
            check40("dataC", dataC_out, e.c);
            check40("dataD", dataD_out, e.d);
            check40("flags", {36'd0, data_valid, sync_active, busy, done}, {36'd0, e.flags});
            if (e.fp) check40("first_payload_A", dataA_out, cur_first);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) tick();
    endtask

    // Drive a start pulse, then scramble the config inputs to prove they were captured.
    task automatic pulse_start(input int md, input logic [9:0] fv, input logic [3:0] sl,
                               input logic [15:0] bl);
        mode = 2'(md); fixed_val = fv; sync_len = sl; burst_len = bl;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = 2'($urandom_range(0, 3)); fixed_val = 10'($urandom);
        sync_len = 4'($urandom); burst_len = 16'($urandom_range(1, 9));
    endtask

    initial begin
        tbl[0] = '{md: 1, fv: 10'h000, sl: 4'd2,  bl: 16'd3,
                   first_a: {10'h203, 10'h202, 10'h201, 10'h200}};
        tbl[1] = '{md: 2, fv: 10'h3FF, sl: 4'd0,  bl: 16'd1, first_a: {4{10'h1FF}}};
        tbl[2] = '{md: 0, fv: 10'h0AA, sl: 4'd1,  bl: 16'd2, first_a: {4{10'h200}}};
`ifdef ADC_TEST_SRC_PRBS_EN
        tbl[3] = '{md: 3, fv: 10'h000, sl: 4'd3,  bl: 16'd40, first_a: {4{10'h3FF}}};
`else
        tbl[3] = '{md: 3, fv: 10'h000, sl: 4'd3,  bl: 16'd40, first_a: {4{10'h200}}};
`endif
        tbl[4] = '{md: 1, fv: 10'h000, sl: 4'd0,  bl: 16'd5,
                   first_a: {10'h203, 10'h202, 10'h201, 10'h200}};
        tbl[5] = '{md: 2, fv: 10'h155, sl: 4'd15, bl: 16'd2, first_a: {4{10'h355}}};

        // Reset held for 3 cycles, then idle with no start.
        rst_n = 1'b0;
        tick();
        push_idle(2);
        tick(); tick();
        rst_n = 1'b1;
        push_idle(4);
        drain();

        for (int v = 0; v < 6; v++) begin
            push_burst(tbl[v].md, tbl[v].fv, int'(tbl[v].sl), int'(tbl[v].bl), 1'b1);
            push_idle(2);
            cur_first = tbl[v].first_a;
            pulse_start(tbl[v].md, tbl[v].fv, tbl[v].sl, tbl[v].bl);
            drain();
        end

        // Continuous ramp, stop while payload k=300 is on the outputs.
        d0 = done_seen;
        cur_first = {10'h203, 10'h202, 10'h201, 10'h200};
        push_burst(1, 10'h000, 1, 301, 1'b1);
        push_idle(2);
        pulse_start(1, 10'h000, 4'd1, 16'd0);
        repeat (301) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain();
        check40("cont_done_count", 40'(done_seen - d0), 40'd1);

        // Reset asserted at RUN k=5: midscale next cycle, no done.
        d0 = done_seen;
        push_burst(1, 10'h000, 0, 6, 1'b0);
        pulse_start(1, 10'h000, 4'd0, 16'd20);
        repeat (5) tick();
        rst_n = 1'b0;
        push_idle(1);
        tick();
        rst_n = 1'b1;
        push_idle(3);
        drain();
        check40("reset_no_done", 40'(done_seen - d0), 40'd0);

        // start during RUN is ignored.
        push_burst(1, 10'h000, 1, 6, 1'b1);
        push_idle(2);
        pulse_start(1, 10'h000, 4'd1, 16'd6);
        tick(); tick();
        mode = 2'd2; burst_len = 16'd1; sync_len = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        drain();

        // stop during SYNC goes straight to DONE.
        push_burst(1, 10'h000, 2, 0, 1'b1);
        push_idle(2);
        pulse_start(1, 10'h000, 4'd4, 16'd3);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain();

        // stop alone in IDLE ignored; start and stop together in IDLE: start wins.
        stop = 1'b1;
        push_idle(2);
        tick(); tick();
        cur_first = {4{10'h201}};
        push_burst(2, 10'h001, 0, 2, 1'b1);
        push_idle(2);
        pulse_start(2, 10'h001, 4'd0, 16'd2);
        stop = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
